// File: rtl/scrambler_pkg.sv
// Shared scrambler definitions: scheduler state encoding and default cut-range constants,
// common to the line-rotation datapath, the descrambler and line_cut_scheduler.
package scrambler_pkg;

    localparam int CUT_WIDTH        = 8;
    localparam int DEF_MIN_CUT      = 16;
    localparam int DEF_MAX_CUT      = 239;
    localparam int DEF_FALLBACK_CUT = 0;

    typedef enum logic [1:0] {
        S_INIT       = 2'd0,
        S_INIT_GAP   = 2'd1,
        S_WAIT_FIELD = 2'd2,
        S_ACTIVE     = 2'd3
    } sched_state_e;

    // Number of legal cut positions; at most 256, so it needs 9 bits.
    function automatic logic [8:0] cut_span(input int min_cut, input int max_cut);
        return 9'(max_cut - min_cut + 1);
    endfunction

endpackage

// File: rtl/line_cut_scheduler_if.sv
// DRBG / byte-consumer side of line_cut_scheduler. master = scheduler, slave = DRBG + consumer.
interface line_cut_scheduler_if;
    // Handshakes: drbg_init is a level held until drbg_init_ready is seen. drbg_next_seed is a
    // one-cycle request the DRBG must queue even while busy. A byte is popped in every cycle where
    // rand_byte_valid and rand_byte_ack are both high; ack is never high two cycles in a row.
    logic       drbg_init_ready;
    logic       drbg_busy;
    logic [7:0] rand_byte;
    logic       rand_byte_valid;
    logic       drbg_init;
    logic       drbg_next_seed;
    logic       rand_byte_ack;

    modport master (
        input  drbg_init_ready, drbg_busy, rand_byte, rand_byte_valid,
        output drbg_init, drbg_next_seed, rand_byte_ack
    );

    modport slave (
        output drbg_init_ready, drbg_busy, rand_byte, rand_byte_valid,
        input  drbg_init, drbg_next_seed, rand_byte_ack
    );
endinterface

// File: rtl/line_cut_scheduler_cut_range_map.sv
// cut_range_map: maps a random byte uniformly onto [MIN_CUT, MAX_CUT].
// Shared with the descrambler so both ends derive bit-identical cuts.
module cut_range_map
    import scrambler_pkg::*;
#(
    parameter int MIN_CUT = DEF_MIN_CUT,
    parameter int MAX_CUT = DEF_MAX_CUT
) (
    input  logic [CUT_WIDTH-1:0] rand_byte,
    output logic [CUT_WIDTH-1:0] cut
);
    localparam logic [8:0] SPAN = cut_span(MIN_CUT, MAX_CUT);

    logic [16:0] product;
    logic [8:0]  unused_product_bits;

    // byte * SPAN < 2^16, so bits [15:8] are the whole scaled value.
    assign product             = {9'd0, rand_byte} * {8'd0, SPAN};
    assign cut                 = CUT_WIDTH'(MIN_CUT) + product[15:8];
    assign unused_product_bits = {product[16], product[7:0]};
endmodule

// File: rtl/line_cut_scheduler.sv
// line_cut_scheduler: DRBG init/reseed sequencing and per-line cut selection.
// Optional stats outputs (and the underflow counter) exist only with LINE_CUT_SCHED_STATS_EN.
module line_cut_scheduler
    import scrambler_pkg::*;
#(
    parameter int MIN_CUT      = DEF_MIN_CUT,
    parameter int MAX_CUT      = DEF_MAX_CUT,
    parameter int FALLBACK_CUT = DEF_FALLBACK_CUT,
    parameter int INIT_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  H,
    input  logic                  V,
    line_cut_scheduler_if.master  drbg,
    output logic [CUT_WIDTH-1:0]  cut_position,
    output logic                  cut_valid,
    output logic                  sched_ready,
    output logic                  init_error,
    output logic [15:0]           underflow_count,
    output sched_state_e          state_dbg
`ifdef LINE_CUT_SCHED_STATS_EN
    ,
    output logic [9:0]            line_in_field,
    output logic [15:0]           busy_at_seed_count
`endif
);
    localparam int CNT_W = (INIT_TIMEOUT > 1) ? $clog2(INIT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]     TO_LAST = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CUT_WIDTH-1:0] FB_CUT  = CUT_WIDTH'(FALLBACK_CUT);

    sched_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  h_d_q, v_d_q;
    logic                  init_q, init_d;
    logic                  seed_q, seed_d;
    logic                  ack_q, ack_d;
    logic [CUT_WIDTH-1:0]  cut_q, cut_d;
    logic                  cut_valid_q, cut_valid_d;
    logic                  init_error_q, init_error_d;
    logic                  underflow_inc;
    logic [CUT_WIDTH-1:0]  mapped_cut;

    logic h_rise, v_rise, v_fall;
    assign h_rise = H & ~h_d_q;
    assign v_rise = V & ~v_d_q;
    assign v_fall = ~V & v_d_q;

    cut_range_map #(
        .MIN_CUT (MIN_CUT),
        .MAX_CUT (MAX_CUT)
    ) u_map (
        .rand_byte (drbg.rand_byte),
        .cut       (mapped_cut)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        init_d        = init_q;
        seed_d        = 1'b0;
        ack_d         = 1'b0;
        cut_d         = cut_q;
        cut_valid_d   = cut_valid_q;
        init_error_d  = init_error_q;
        underflow_inc = 1'b0;
        unique case (state_q)
            S_INIT: begin
                if (drbg.drbg_init_ready) begin
                    init_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT_FIELD;
                end else if (cnt_q == TO_LAST) begin
                    // Drop the request for one cycle so the DRBG sees a fresh init.
                    init_error_d = 1'b1;
                    init_d       = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_INIT_GAP;
                end else begin
                    init_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            S_INIT_GAP: begin
                init_d  = 1'b1;
                state_d = S_INIT;
            end
            S_WAIT_FIELD: begin
                cut_valid_d = 1'b0;
                if (v_fall) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                // Field end takes priority over a coincident line start.
                if (v_rise) begin
                    seed_d      = 1'b1;
                    cut_valid_d = 1'b0;
                    cut_d       = FB_CUT;
                    state_d     = S_WAIT_FIELD;
                end else if (h_rise) begin
                    if (drbg.rand_byte_valid) begin
                        ack_d       = 1'b1;
                        cut_d       = mapped_cut;
                        cut_valid_d = 1'b1;
                    end else begin
                        cut_d         = FB_CUT;
                        cut_valid_d   = 1'b0;
                        underflow_inc = 1'b1;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            h_d_q        <= 1'b1;
            v_d_q        <= 1'b1;
            init_q       <= 1'b0;
            seed_q       <= 1'b0;
            ack_q        <= 1'b0;
            cut_q        <= FB_CUT;
            cut_valid_q  <= 1'b0;
            init_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            h_d_q        <= H;
            v_d_q        <= V;
            init_q       <= init_d;
            seed_q       <= seed_d;
            ack_q        <= ack_d;
            cut_q        <= cut_d;
            cut_valid_q  <= cut_valid_d;
            init_error_q <= init_error_d;
        end
    end

    assign drbg.drbg_init      = init_q;
    assign drbg.drbg_next_seed = seed_q;
    assign drbg.rand_byte_ack  = ack_q;
    assign cut_position        = cut_q;
    assign cut_valid           = cut_valid_q;
    assign init_error          = init_error_q;
    assign sched_ready         = (state_q == S_WAIT_FIELD) || (state_q == S_ACTIVE);
    assign state_dbg           = state_q;

`ifdef LINE_CUT_SCHED_STATS_EN
    logic [15:0] uf_q, uf_d;
    logic [9:0]  line_q, line_d;
    logic [15:0] bseed_q, bseed_d;

    always_comb begin
        uf_d    = uf_q;
        line_d  = line_q;
        bseed_d = bseed_q;
        if (underflow_inc && uf_q != 16'hFFFF) uf_d = uf_q + 16'd1;
        if (v_fall) line_d = '0;
        else if (h_rise && line_q != 10'h3FF) line_d = line_q + 10'd1;
        if (v_rise && drbg.drbg_busy && bseed_q != 16'hFFFF) bseed_d = bseed_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uf_q    <= '0;
            line_q  <= '0;
            bseed_q <= '0;
        end else begin
            uf_q    <= uf_d;
            line_q  <= line_d;
            bseed_q <= bseed_d;
        end
    end

    assign underflow_count    = uf_q;
    assign line_in_field      = line_q;
    assign busy_at_seed_count = bseed_q;
`else
    logic [1:0] unused_stats_inputs;
    assign unused_stats_inputs = {drbg.drbg_busy, underflow_inc};
    assign underflow_count     = '0;
`endif
endmodule

// File: tb/tb_line_cut_scheduler.sv
// Directed bench for line_cut_scheduler: init handshake, init timeout (second instance),
// cut mapping, underflow, V/H collision and mid-line reset.
module tb_line_cut_scheduler;
    import scrambler_pkg::*;

    logic clk;
    logic reset, rst2;
    logic H, V;
    int   n_pass, n_total;

    line_cut_scheduler_if ifc ();
    line_cut_scheduler_if ifc2 ();

    logic [7:0]   cut_position, cut2;
    logic         cut_valid, sched_ready, init_error, cv2, sr2, ie2;
    logic [15:0]  underflow_count, uf2;
    sched_state_e state_dbg, st2;
`ifdef LINE_CUT_SCHED_STATS_EN
    logic [9:0]   line_in_field, line2;
    logic [15:0]  busy_at_seed_count, bseed2;
    localparam logic [15:0] EXP_UF1 = 16'd1;
`else
    localparam logic [15:0] EXP_UF1 = 16'd0;
`endif

    line_cut_scheduler dut (
        .clk (clk), .reset (reset), .H (H), .V (V), .drbg (ifc),
        .cut_position (cut_position), .cut_valid (cut_valid), .sched_ready (sched_ready),
        .init_error (init_error), .underflow_count (underflow_count), .state_dbg (state_dbg)
`ifdef LINE_CUT_SCHED_STATS_EN
        , .line_in_field (line_in_field), .busy_at_seed_count (busy_at_seed_count)
`endif
    );

    line_cut_scheduler #(.INIT_TIMEOUT (16)) dut_to (
        .clk (clk), .reset (rst2), .H (1'b0), .V (1'b1), .drbg (ifc2),
        .cut_position (cut2), .cut_valid (cv2), .sched_ready (sr2),
        .init_error (ie2), .underflow_count (uf2), .state_dbg (st2)
`ifdef LINE_CUT_SCHED_STATS_EN
        , .line_in_field (line2), .busy_at_seed_count (bseed2)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one line: byte presented at the line start, consumer withdraws it after the pop.
    task automatic drive_line(input logic [7:0] b, input logic bv, output int acks,
                              output logic [7:0] cut_at, output logic cv_at,
                              output logic [7:0] cut_end);
        ifc.rand_byte       = b;
        ifc.rand_byte_valid = bv;
        H                   = 1'b1;
        acks                = 0;
        cut_at              = 8'hxx;
        cv_at               = 1'bx;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifc.rand_byte_ack === 1'b1) acks++;
            if (i == 0) begin
                cut_at              = cut_position;
                cv_at               = cut_valid;
                ifc.rand_byte_valid = 1'b0;
            end
            if (i == 2) H = 1'b0;
        end
        cut_end = cut_position;
    endtask

    task automatic test_reset();
        reset = 1'b1; rst2 = 1'b1; H = 1'b0; V = 1'b1;
        ifc.drbg_init_ready = 1'b0; ifc.drbg_busy = 1'b0;
        ifc.rand_byte = 8'h00; ifc.rand_byte_valid = 1'b0;
        ifc2.drbg_init_ready = 1'b0; ifc2.drbg_busy = 1'b0;
        ifc2.rand_byte = 8'h00; ifc2.rand_byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (ifc.drbg_init !== 1'b0) $display("FAIL rst_init: got %b need 0", ifc.drbg_init); else n_pass++;
        n_total++; if (ifc.drbg_next_seed !== 1'b0) $display("FAIL rst_seed: got %b need 0", ifc.drbg_next_seed); else n_pass++;
        n_total++; if (ifc.rand_byte_ack !== 1'b0) $display("FAIL rst_ack: got %b need 0", ifc.rand_byte_ack); else n_pass++;
        n_total++; if (cut_position !== 8'd0) $display("FAIL rst_cut: got %0d need 0", cut_position); else n_pass++;
        n_total++; if (cut_valid !== 1'b0) $display("FAIL rst_cut_valid: got %b need 0", cut_valid); else n_pass++;
        n_total++; if (sched_ready !== 1'b0) $display("FAIL rst_ready: got %b need 0", sched_ready); else n_pass++;
        n_total++; if (init_error !== 1'b0 || ie2 !== 1'b0) $display("FAIL rst_init_error: got %b/%b need 0/0", init_error, ie2); else n_pass++;
        n_total++; if (underflow_count !== 16'd0) $display("FAIL rst_underflow: got %0d need 0", underflow_count); else n_pass++;
        n_total++; if (state_dbg !== S_INIT) $display("FAIL rst_state: got %0d need %0d", state_dbg, S_INIT); else n_pass++;
    endtask

    task automatic test_init_handshake();
        int bad;
        bad   = 0;
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ifc.drbg_init !== 1'b1 || sched_ready !== 1'b0) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL init_high_0_39: bad cycles %0d need 0", bad); else n_pass++;
        ifc.drbg_init_ready = 1'b1;
        @(negedge clk);
        n_total++; if (ifc.drbg_init !== 1'b0) $display("FAIL init_low_40: got %b need 0", ifc.drbg_init); else n_pass++;
        @(negedge clk);
        n_total++; if (sched_ready !== 1'b1) $display("FAIL ready_41: got %b need 1", sched_ready); else n_pass++;
        n_total++; if (state_dbg !== S_WAIT_FIELD) $display("FAIL state_wait: got %0d need %0d", state_dbg, S_WAIT_FIELD); else n_pass++;
    endtask

    task automatic test_init_timeout();
        int   bad, ie_bad;
        logic e;
        bad = 0; ie_bad = 0;
        rst2 = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            e = (k >= 15 && ((k - 15) % 17) == 0) ? 1'b0 : 1'b1;
            if (ifc2.drbg_init !== e) bad++;
            if (ie2 !== (k >= 15)) ie_bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL timeout_init_pattern: bad cycles %0d need 0", bad); else n_pass++;
        n_total++; if (ie_bad !== 0) $display("FAIL timeout_init_error: bad cycles %0d need 0", ie_bad); else n_pass++;
        n_total++; if (sr2 !== 1'b0) $display("FAIL timeout_ready: got %b need 0", sr2); else n_pass++;
    endtask

    task automatic test_active_cuts();
        logic [7:0] exp_q[$];
        logic [7:0] bytes [3];
        logic [7:0] e, cut_at, cut_end;
        logic       cv_at;
        int         acks;
        bytes = '{8'h80, 8'hFF, 8'h00};
        exp_q.push_back(8'd128);
        exp_q.push_back(8'd239);
        exp_q.push_back(8'd16);
        V = 1'b0;
        @(negedge clk);
        n_total++; if (state_dbg !== S_ACTIVE) $display("FAIL state_active: got %0d need %0d", state_dbg, S_ACTIVE); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive_line(bytes[i], 1'b1, acks, cut_at, cv_at, cut_end);
            e = exp_q.pop_front();
            n_total++; if (cut_at !== e) $display("FAIL cut_%0d: got %0d need %0d", i, cut_at, e); else n_pass++;
            n_total++; if (cv_at !== 1'b1) $display("FAIL cut_valid_%0d: got %b need 1", i, cv_at); else n_pass++;
            n_total++; if (acks !== 1) $display("FAIL ack_count_%0d: got %0d need 1", i, acks); else n_pass++;
            n_total++; if (cut_end !== e) $display("FAIL cut_held_%0d: got %0d need %0d", i, cut_end, e); else n_pass++;
        end
    endtask

    task automatic test_underflow();
        logic [7:0] cut_at, cut_end;
        logic       cv_at;
        int         acks;
        n_total++; if (underflow_count !== 16'd0) $display("FAIL uf_before: got %0d need 0", underflow_count); else n_pass++;
        drive_line(8'hAA, 1'b0, acks, cut_at, cv_at, cut_end);
        n_total++; if (cut_at !== 8'd0) $display("FAIL uf_cut: got %0d need 0", cut_at); else n_pass++;
        n_total++; if (cv_at !== 1'b0) $display("FAIL uf_cut_valid: got %b need 0", cv_at); else n_pass++;
        n_total++; if (acks !== 0) $display("FAIL uf_ack: got %0d need 0", acks); else n_pass++;
        n_total++; if (underflow_count !== EXP_UF1) $display("FAIL uf_count: got %0d need %0d", underflow_count, EXP_UF1); else n_pass++;
`ifdef LINE_CUT_SCHED_STATS_EN
        n_total++; if (line_in_field !== 10'd4) $display("FAIL line_in_field: got %0d need 4", line_in_field); else n_pass++;
`endif
    endtask

    task automatic test_hv_same_cycle();
        logic [7:0] cut_at, cut_end;
        logic       cv_at;
        int         acks, seeds;
        drive_line(8'h40, 1'b1, acks, cut_at, cv_at, cut_end);
        n_total++; if (cut_at !== 8'd72 || cv_at !== 1'b1) $display("FAIL pre_hv_cut: got %0d/%b need 72/1", cut_at, cv_at); else n_pass++;
`ifdef LINE_CUT_SCHED_STATS_EN
        n_total++; if (line_in_field !== 10'd5) $display("FAIL pre_hv_lines: got %0d need 5", line_in_field); else n_pass++;
`endif
        ifc.rand_byte = 8'h80; ifc.rand_byte_valid = 1'b1; ifc.drbg_busy = 1'b1;
        H = 1'b1; V = 1'b1;
        seeds = 0; acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifc.drbg_next_seed === 1'b1) seeds++;
            if (ifc.rand_byte_ack === 1'b1) acks++;
            if (i == 2) H = 1'b0;
        end
        ifc.drbg_busy = 1'b0;
        n_total++; if (seeds !== 1) $display("FAIL hv_seed_pulses: got %0d need 1", seeds); else n_pass++;
        n_total++; if (acks !== 0) $display("FAIL hv_acks: got %0d need 0", acks); else n_pass++;
        n_total++; if (state_dbg !== S_WAIT_FIELD) $display("FAIL hv_state: got %0d need %0d", state_dbg, S_WAIT_FIELD); else n_pass++;
        n_total++; if (cut_position !== 8'd0 || cut_valid !== 1'b0) $display("FAIL hv_cut: got %0d/%b need 0/0", cut_position, cut_valid); else n_pass++;
        n_total++; if (underflow_count !== EXP_UF1) $display("FAIL hv_uf: got %0d need %0d", underflow_count, EXP_UF1); else n_pass++;
`ifdef LINE_CUT_SCHED_STATS_EN
        n_total++; if (busy_at_seed_count !== 16'd1) $display("FAIL busy_at_seed: got %0d need 1", busy_at_seed_count); else n_pass++;
`endif
        seeds = 0;
        for (int l = 0; l < 2; l++) begin
            drive_line(8'h33, 1'b1, acks, cut_at, cv_at, cut_end);
            seeds += acks;
        end
        n_total++; if (seeds !== 0) $display("FAIL wait_field_pops: got %0d need 0", seeds); else n_pass++;
        n_total++; if (state_dbg !== S_WAIT_FIELD) $display("FAIL wait_field_state: got %0d need %0d", state_dbg, S_WAIT_FIELD); else n_pass++;
    endtask

    task automatic test_reset_mid_line();
        V = 1'b0;
        @(negedge clk);
        ifc.rand_byte = 8'hFF; ifc.rand_byte_valid = 1'b1; H = 1'b1;
        @(negedge clk);
        n_total++; if (ifc.rand_byte_ack !== 1'b1 || cut_position !== 8'd239) $display("FAIL mid_pop: got %b/%0d need 1/239", ifc.rand_byte_ack, cut_position); else n_pass++;
        ifc.rand_byte_valid = 1'b0;
        @(negedge clk);
        ifc.drbg_init_ready = 1'b0;
        reset = 1'b1;
        #1;
        n_total++; if (cut_position !== 8'd0 || cut_valid !== 1'b0) $display("FAIL mid_rst_cut: got %0d/%b need 0/0", cut_position, cut_valid); else n_pass++;
        n_total++; if (ifc.rand_byte_ack !== 1'b0 || ifc.drbg_next_seed !== 1'b0 || ifc.drbg_init !== 1'b0) $display("FAIL mid_rst_drbg: got ack %b seed %b init %b need 0 0 0", ifc.rand_byte_ack, ifc.drbg_next_seed, ifc.drbg_init); else n_pass++;
        n_total++; if (sched_ready !== 1'b0 || init_error !== 1'b0) $display("FAIL mid_rst_status: got %b/%b need 0/0", sched_ready, init_error); else n_pass++;
        n_total++; if (state_dbg !== S_INIT) $display("FAIL mid_rst_state: got %0d need %0d", state_dbg, S_INIT); else n_pass++;
        n_total++; if (underflow_count !== 16'd0) $display("FAIL mid_rst_uf: got %0d need 0", underflow_count); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (ifc.drbg_init !== 1'b1) $display("FAIL reinit: got %b need 1", ifc.drbg_init); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_init_handshake();
        test_init_timeout();
        test_active_cuts();
        test_underflow();
        test_hv_same_cycle();
        test_reset_mid_line();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/line_cut_scheduler.md
Name: line_cut_scheduler

Overview:
Sequences the double-hash DRBG and its byte-serialising consumer for the video scrambler. Performs DRBG instantiation after reset and requests a reseed at every vertical-blanking start. At each line boundary it pops one random byte from the consumer and maps it to a bounded per-line cut position. The cut position is held stable for the line scrambler/descrambler. Sits between sync_parser, double_hash_drbg / hash_drbg_consumer, and the line-rotation datapath.

Parameters:
MIN_CUT, 16, smallest legal cut position (pixels).
MAX_CUT, 239, largest legal cut position; MIN_CUT <= MAX_CUT <= 255.
FALLBACK_CUT, 0, cut used on underflow.
INIT_TIMEOUT, 4096, cycles to wait for drbg_init_ready before retrying init.

Ports:
clk  in  1  system clock (27 MHz video clock)
reset  in  1  asynchronous, active-high reset
H  in  1  horizontal blanking flag from sync_parser
V  in  1  vertical blanking flag from sync_parser
drbg_init_ready  in  1  DRBG instantiation done
drbg_busy  in  1  DRBG generator busy
rand_byte  in  8  consumer serial byte
rand_byte_valid  in  1  rand_byte holds an unconsumed byte
drbg_init  out  1  init request, level
drbg_next_seed  out  1  reseed request, 1-cycle pulse
rand_byte_ack  out  1  pop of rand_byte, 1-cycle pulse
cut_position  out  8  current line cut
cut_valid  out  1  cut_position derived from DRBG for this line
sched_ready  out  1  high in S_WAIT_FIELD/S_ACTIVE
init_error  out  1  sticky: at least one init timeout since reset
underflow_count  out  16  lines that fell back (saturating)

Behaviour:
- Reset (async): state S_INIT. All outputs 0, except cut_position = FALLBACK_CUT. Timeout counter 0. H_d/V_d = 1, so no edge is detected immediately after release.
- Edge detect: registered H_d, V_d. h_rise = H & ~H_d; v_rise = V & ~V_d; v_fall = ~V & V_d.
- S_INIT: drbg_init = 1. Timeout counter increments each cycle.
  - drbg_init_ready = 1 -> drbg_init = 0; go to S_WAIT_FIELD.
  - Counter reaches INIT_TIMEOUT-1 -> set init_error; drive drbg_init = 0 for exactly 1 cycle (S_INIT_GAP); counter = 0; return to S_INIT.
- S_WAIT_FIELD: on v_fall -> S_ACTIVE. No pops. cut_valid = 0.
- S_ACTIVE:
  - On h_rise with rand_byte_valid = 1:
    - rand_byte_ack = 1 next cycle.
    - cut_position = MIN_CUT + ((rand_byte * (MAX_CUT-MIN_CUT+1)) >> 8), computed with a 17-bit product, registered.
    - cut_valid = 1.
    - Latency: both cut_position and rand_byte_ack are updated at the edge following the first sampled H = 1.
  - On h_rise with rand_byte_valid = 0: cut_position = FALLBACK_CUT; cut_valid = 0; underflow_count += 1, saturating at 0xFFFF; no ack.
  - On v_rise: drbg_next_seed pulses 1 cycle; cut_valid = 0; cut_position = FALLBACK_CUT; go to S_WAIT_FIELD.
  - v_rise and h_rise in the same cycle: v_rise wins; no pop, no underflow count.
- drbg_next_seed is issued regardless of drbg_busy; the DRBG queues it. drbg_busy only gates nothing, and is exported to the stats logic.
- rand_byte_ack never asserts for 2 consecutive cycles.
- Reset asserted mid-field: immediate return to S_INIT. DRBG re-instantiation is required.

Optional Feature:
LINE_CUT_SCHED_STATS_EN. When defined, adds outputs:
- line_in_field [9:0]: h_rise count since v_fall, reset on v_fall, saturating at 1023.
- busy_at_seed_count [15:0]: v_rise events seen while drbg_busy = 1, saturating.
When undefined, these ports are absent, and underflow_count is tied to 0 with its counter not synthesised.

Decomposition:
Shared package (scrambler_pkg) holds:
- state encodings: S_INIT, S_INIT_GAP, S_WAIT_FIELD, S_ACTIVE
- default MIN_CUT / MAX_CUT / FALLBACK_CUT constants, common with the line-rotation datapath and descrambler
- CUT_WIDTH = 8
One sub-module, cut_range_map: combinational scale-and-offset, reused by the descrambler so both ends compute identical cuts.

Test Plan:
1. Reset release; drbg_init_ready rises at cycle 40 -> drbg_init high for cycles 0..39, low from cycle 40; sched_ready = 1 at cycle 41.
2. drbg_init_ready held 0, INIT_TIMEOUT = 16 -> drbg_init low for exactly 1 cycle every 17 cycles; init_error = 1 after the first timeout.
3. In S_ACTIVE, rand_byte = 0x80/0xFF/0x00 on three lines -> cut_position = 128/239/16, cut_valid = 1, one rand_byte_ack pulse per line.
4. rand_byte_valid = 0 at h_rise -> cut_position = 0, cut_valid = 0, underflow_count 0 -> 1, no ack.
5. H and V rise in the same cycle -> single drbg_next_seed pulse, no ack, state S_WAIT_FIELD; no pops until V falls.
6. Reset pulsed mid-line after a pop -> all outputs 0, cut_position = FALLBACK_CUT, drbg_init reasserts the cycle after reset deasserts.
